// File: rtl/counter_readout_if.sv
// counter_readout_if: byte stream toward the host link (valid/ready handshake).
// The master drives data/valid and the slave drives ready.
interface counter_readout_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/counter_readout.sv
// counter_readout: snapshots the counter bank on capture, pulses counter_clear, and streams the frame.
// Define CNT_READOUT_CHECKSUM_EN to append a CHECK byte (XOR of all preceding frame bytes).
module counter_readout #(
    parameter int unsigned NUM_COUNTERS = 4,
    parameter int unsigned RESOLUTION   = 64,
    parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               capture,
    input  logic [NUM_COUNTERS*RESOLUTION-1:0] counters_in,
    input  logic [NUM_COUNTERS-1:0]            overflow_in,
    output logic                               counter_clear,
    counter_readout_if.master                  out_if,
    output logic                               busy
);
    localparam int unsigned NB = RESOLUTION / 8;
    localparam int unsigned CW = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_CH   = CW'(NUM_COUNTERS - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

`ifdef CNT_READOUT_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HEADER, FLAGS, DATA, CHECK} state_t;
`else
    typedef enum logic [1:0] {IDLE, HEADER, FLAGS, DATA} state_t;
`endif

    state_t                             state_q, state_d;
    logic [NUM_COUNTERS*RESOLUTION-1:0] snap_val_q, snap_val_d;
    logic [NUM_COUNTERS-1:0]            snap_ovf_q, snap_ovf_d;
    logic                               dropped_q, dropped_d;
    logic                               frame_drop_q, frame_drop_d;
    logic                               clear_q, clear_d;
    logic [CW-1:0]                      ch_q, ch_d;
    logic [BW-1:0]                      byte_q, byte_d;
`ifdef CNT_READOUT_CHECKSUM_EN
    logic [7:0]                         csum_q, csum_d;
`endif
    logic [RESOLUTION-1:0]              chan_word;
    logic                               chan_ovf;
    logic [7:0]                         data_byte;
    logic [7:0]                         tx_byte;
    logic                               valid;
    logic                               xfer;

    assign valid             = (state_q != IDLE);
    assign xfer              = valid && out_if.out_ready;
    assign out_if.out_valid  = valid;
    assign out_if.out_data   = tx_byte;
    assign busy              = valid;
    assign counter_clear     = clear_q;

    always_comb begin
        chan_word = '0;
        chan_ovf  = 1'b0;
        for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
            if (ch_q == CW'(i)) begin
                chan_word = snap_val_q[i*RESOLUTION +: RESOLUTION];
                chan_ovf  = snap_ovf_q[i];
            end
        end
        // byte index 0 is the most significant byte of the channel word
        data_byte = '0;
        for (int unsigned j = 0; j < NB; j++) begin
            if (byte_q == BW'(j)) data_byte = chan_word[(NB-1-j)*8 +: 8];
        end
    end

    always_comb begin
        tx_byte = '0;
        case (state_q)
            HEADER:  tx_byte = HEADER_BYTE;
            FLAGS:   tx_byte = {6'(ch_q), frame_drop_q, chan_ovf};
            DATA:    tx_byte = data_byte;
`ifdef CNT_READOUT_CHECKSUM_EN
            CHECK:   tx_byte = csum_q;
`endif
            default: tx_byte = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        snap_val_d   = snap_val_q;
        snap_ovf_d   = snap_ovf_q;
        dropped_d    = dropped_q;
        frame_drop_d = frame_drop_q;
        clear_d      = 1'b0;
        ch_d         = ch_q;
        byte_d       = byte_q;
`ifdef CNT_READOUT_CHECKSUM_EN
        csum_d       = xfer ? (csum_q ^ tx_byte) : csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d      = HEADER;
                    snap_val_d   = counters_in;
                    snap_ovf_d   = overflow_in;
                    frame_drop_d = dropped_q;
                    dropped_d    = 1'b0;
                    clear_d      = 1'b1;
                    ch_d         = '0;
                    byte_d       = '0;
`ifdef CNT_READOUT_CHECKSUM_EN
                    csum_d       = '0;
`endif
                end
            end
            HEADER: if (xfer) state_d = FLAGS;
            FLAGS: begin
                if (xfer) begin
                    state_d = DATA;
                    byte_d  = '0;
                end
            end
            DATA: begin
                if (xfer) begin
                    if (byte_q == LAST_BYTE) begin
                        byte_d = '0;
                        if (ch_q == LAST_CH) begin
`ifdef CNT_READOUT_CHECKSUM_EN
                            state_d = CHECK;
`else
                            state_d = IDLE;
`endif
                        end else begin
                            ch_d    = ch_q + 1'b1;
                            state_d = FLAGS;
                        end
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end
`ifdef CNT_READOUT_CHECKSUM_EN
            CHECK: if (xfer) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
        // a capture that cannot be serviced is remembered for the next frame
        if (capture && valid) dropped_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            snap_val_q   <= '0;
            snap_ovf_q   <= '0;
            dropped_q    <= 1'b0;
            frame_drop_q <= 1'b0;
            clear_q      <= 1'b0;
            ch_q         <= '0;
            byte_q       <= '0;
`ifdef CNT_READOUT_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            snap_val_q   <= snap_val_d;
            snap_ovf_q   <= snap_ovf_d;
            dropped_q    <= dropped_d;
            frame_drop_q <= frame_drop_d;
            clear_q      <= clear_d;
            ch_q         <= ch_d;
            byte_q       <= byte_d;
`ifdef CNT_READOUT_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_counter_readout.sv
// tb_counter_readout: self-checking bench for counter_readout with a frame-level reference model.
// Follows CNT_READOUT_CHECKSUM_EN to decide whether a CHECK byte is expected.
module tb_counter_readout;
    localparam int unsigned NUM = 2;
    localparam int unsigned RES = 16;
    localparam int unsigned NB  = RES / 8;
    localparam logic [7:0]  HDR = 8'hA5;

    typedef logic [7:0]         bq_t[$];
    typedef logic [NUM*RES-1:0] vals_t;
    typedef logic [NUM-1:0]     ovf_t;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    logic  capture = 1'b0;
    vals_t counters_in = '0;
    ovf_t  overflow_in = '0;
    logic  counter_clear;
    logic  busy;
    int unsigned errors = 0;
    int unsigned checks = 0;

    counter_readout_if bus ();

    counter_readout #(.NUM_COUNTERS(NUM), .RESOLUTION(RES), .HEADER_BYTE(HDR)) dut (
        .clk(clk), .reset(reset), .capture(capture), .counters_in(counters_in),
        .overflow_in(overflow_in), .counter_clear(counter_clear), .out_if(bus), .busy(busy)
    );

    always #5 clk = ~clk;

    // Frame built straight from the frame-format rules.
    function automatic bq_t model_frame(input vals_t vals, input ovf_t ovf, input bit drop);
        bq_t q;
        q.push_back(HDR);
        for (int unsigned i = 0; i < NUM; i++) begin
            q.push_back(8'((i * 4) + (drop ? 2 : 0) + (ovf[i] ? 1 : 0)));
            for (int b = int'(NB) - 1; b >= 0; b--) q.push_back(8'(vals >> (i * RES + b * 8)));
        end
`ifdef CNT_READOUT_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            foreach (q[k]) x ^= q[k];
            q.push_back(x);
        end
`endif
        return q;
    endfunction

    // Runs one frame from the capture edge; mode 0 ready=1, 1 ready pattern 1,0,0, 2 random.
    task automatic collect(input int unsigned mode, input int recap_at, output bq_t got,
                           output int unsigned clr_cnt, output int unsigned clr_n,
                           output int unsigned valid_cyc, output int unsigned first_n,
                           output int unsigned hold_bad, output int unsigned busy_bad,
                           output bit timed_out);
        logic       stalled, rdy;
        logic [7:0] held;
        bit         seen, recapped;
        got = {}; clr_cnt = 0; clr_n = 999; valid_cyc = 0; first_n = 999;
        hold_bad = 0; busy_bad = 0; timed_out = 1;
        stalled = 1'b0; held = '0; seen = 0; recapped = 0;
        for (int unsigned n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            capture = (recap_at >= 0 && !recapped && seen && int'(got.size()) == recap_at);
            if (capture) recapped = 1;
            counters_in = vals_t'({$urandom(), $urandom()});
            overflow_in = ovf_t'($urandom());
            if (counter_clear === 1'b1) begin
                if (clr_cnt == 0) clr_n = n;
                clr_cnt++;
            end
            if (busy !== bus.out_valid) busy_bad++;
            if (stalled && (bus.out_valid !== 1'b1 || bus.out_data !== held)) hold_bad++;
            if (bus.out_valid !== 1'b1 && seen) begin
                timed_out = 0;
                break;
            end
            if (bus.out_valid === 1'b1) begin
                if (!seen) first_n = n;
                seen = 1;
                valid_cyc++;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (valid_cyc % 3 == 1);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = rdy;
            if (bus.out_valid === 1'b1 && rdy) begin
                got.push_back(bus.out_data);
                stalled = 1'b0;
            end else begin
                stalled = (bus.out_valid === 1'b1);
                held    = bus.out_data;
            end
        end
        bus.out_ready = 1'b0;
        capture = 1'b0;
    endtask

    task automatic start_frame(input vals_t v, input ovf_t o);
        counters_in = v;
        overflow_in = o;
        capture     = 1'b1;
    endtask

    task automatic test_reset;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 capture = 1'b1;
        @(posedge clk); #1;
        capture = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (counter_clear !== 1'b0) begin errors++; $display("FAIL rst_clear: got %b want 0", counter_clear); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", bus.out_data); end
        reset = 1'b1;
    endtask

    task automatic test_single_frame;
        bq_t got, lit;
        int unsigned clr, cn, vc, fn, hb, bb;
        bit to;
        lit = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h05, 8'hFF, 8'hFE};
`ifdef CNT_READOUT_CHECKSUM_EN
        lit.push_back(8'h87);
`endif
        start_frame({16'hFFFE, 16'h1234}, 2'b10);
        collect(0, -1, got, clr, cn, vc, fn, hb, bb, to);
        checks++; if (to) begin errors++; $display("FAIL t1_timeout: got timeout want frame end"); end
        checks++; if (got.size() !== lit.size()) begin errors++; $display("FAIL t1_len: got %0d want %0d", got.size(), lit.size()); end
        foreach (lit[i]) begin
            checks++;
            if (i >= got.size() || got[i] !== lit[i]) begin
                errors++; $display("FAIL t1_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, lit[i]);
            end
        end
        checks++; if (fn !== 0) begin errors++; $display("FAIL t1_first_valid: got cycle %0d want 0", fn); end
        checks++; if (clr !== 1 || cn !== 0) begin errors++; $display("FAIL t1_clear: got %0d pulses at %0d want 1 at 0", clr, cn); end
        checks++; if (vc !== lit.size()) begin errors++; $display("FAIL t1_no_bubbles: got %0d valid cycles want %0d", vc, lit.size()); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL t1_busy: got %0d busy/valid disagreements want 0", bb); end
    endtask

    task automatic test_stall;
        bq_t got, exp;
        int unsigned clr, cn, vc, fn, hb, bb;
        bit to;
        exp = model_frame({16'hFFFE, 16'h1234}, 2'b10, 1'b0);
        start_frame({16'hFFFE, 16'h1234}, 2'b10);
        collect(1, -1, got, clr, cn, vc, fn, hb, bb, to);
        checks++; if (to) begin errors++; $display("FAIL t2_timeout: got timeout want frame end"); end
        checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL t2_len: got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errors++; $display("FAIL t2_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            end
        end
        checks++; if (hb !== 0) begin errors++; $display("FAIL t2_hold: got %0d unstable stall cycles want 0", hb); end
        checks++; if (vc !== 3 * exp.size() - 2) begin errors++; $display("FAIL t2_valid_cycles: got %0d want %0d", vc, 3 * exp.size() - 2); end
        checks++; if (clr !== 1) begin errors++; $display("FAIL t2_clear: got %0d pulses want 1", clr); end
    endtask

    task automatic test_dropped;
        bq_t got, exp;
        int unsigned clr, cn, vc, fn, hb, bb;
        bit to;
        exp = model_frame({16'hFFFE, 16'h1234}, 2'b10, 1'b0);
        start_frame({16'hFFFE, 16'h1234}, 2'b10);
        collect(0, 3, got, clr, cn, vc, fn, hb, bb, to);
        checks++; if (clr !== 1) begin errors++; $display("FAIL t3_no_second_clear: got %0d pulses want 1", clr); end
        checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL t3a_len: got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errors++; $display("FAIL t3a_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            end
        end
        exp = model_frame({16'hFFFE, 16'h1234}, 2'b10, 1'b1);
        start_frame({16'hFFFE, 16'h1234}, 2'b10);
        collect(2, -1, got, clr, cn, vc, fn, hb, bb, to);
        checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL t3b_len: got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errors++; $display("FAIL t3b_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            end
        end
        checks++; if (exp[1] !== 8'h02 || exp[2 + NB] !== 8'h07) begin errors++; $display("FAIL t3b_model_flags: got %h/%h want 02/07", exp[1], exp[2 + NB]); end
        exp = model_frame({16'h0001, 16'h8000}, 2'b01, 1'b0);
        start_frame({16'h0001, 16'h8000}, 2'b01);
        collect(0, -1, got, clr, cn, vc, fn, hb, bb, to);
        checks++; if (got.size() < 2 || got[1] !== exp[1]) begin errors++; $display("FAIL t3c_dropped_cleared: got flags %h want %h", (got.size() > 1) ? got[1] : 8'hxx, exp[1]); end
    endtask

    task automatic test_reset_midframe;
        bq_t got, exp;
        int unsigned clr, cn, vc, fn, hb, bb, stray;
        bit to;
        start_frame({16'hBEEF, 16'hCAFE}, 2'b11);
        bus.out_ready = 1'b1;
        @(posedge clk); #1 capture = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t4_async_valid: got %b want 0", bus.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_async_busy: got %b want 0", busy); end
        checks++; if (counter_clear !== 1'b0) begin errors++; $display("FAIL t4_async_clear: got %b want 0", counter_clear); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        stray = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        bus.out_ready = 1'b0;
        checks++; if (stray !== 0) begin errors++; $display("FAIL t4_no_resume: got %0d active cycles want 0", stray); end
        exp = model_frame({16'h7F00, 16'h00FF}, 2'b01, 1'b0);
        start_frame({16'h7F00, 16'h00FF}, 2'b01);
        collect(2, -1, got, clr, cn, vc, fn, hb, bb, to);
        checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL t4_len: got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errors++; $display("FAIL t4_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        bq_t got, exp;
        int unsigned clr, cn, vc, fn, hb, bb;
        bit to;
        start_frame({16'h1111, 16'h2222}, 2'b00);
        collect(0, -1, got, clr, cn, vc, fn, hb, bb, to);
        exp = model_frame({16'hA5A5, 16'h5A5A}, 2'b10, 1'b0);
        start_frame({16'hA5A5, 16'h5A5A}, 2'b10);
        collect(0, -1, got, clr, cn, vc, fn, hb, bb, to);
        checks++; if (fn !== 0) begin errors++; $display("FAIL t6_first_valid: got cycle %0d want 0", fn); end
        checks++; if (clr !== 1 || cn !== 0) begin errors++; $display("FAIL t6_clear: got %0d pulses at %0d want 1 at 0", clr, cn); end
        checks++; if (got.size() !== exp.size()) begin errors++; $display("FAIL t6_len: got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                errors++; $display("FAIL t6_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_random;
        bq_t got, exp;
        int unsigned clr, cn, vc, fn, hb, bb;
        bit to;
        vals_t v;
        ovf_t  o;
        for (int unsigned f = 0; f < 6; f++) begin
            v = vals_t'({$urandom(), $urandom()});
            o = ovf_t'($urandom());
            exp = model_frame(v, o, 1'b0);
            start_frame(v, o);
            collect(2, -1, got, clr, cn, vc, fn, hb, bb, to);
            checks++; if (got.size() !== exp.size() || to) begin errors++; $display("FAIL rnd%0d_len: got %0d want %0d", f, got.size(), exp.size()); end
            foreach (exp[i]) begin
                checks++;
                if (i >= got.size() || got[i] !== exp[i]) begin
                    errors++; $display("FAIL rnd%0d_byte%0d: got %h want %h", f, i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
                end
            end
            checks++; if (hb !== 0 || bb !== 0) begin errors++; $display("FAIL rnd%0d_handshake: got hold=%0d busy=%0d want 0/0", f, hb, bb); end
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_stall();
        test_dropped();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
